mem_access: RTL and testbench

//  Pipeline stage directly after Execute. Consumes the EX_* outputs of Execute.

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/mem_access_watchdog.sv | 48 ++++
 rtl/mem_access.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_pkg
//   Shared definitions for the memory-access pipeline stage:
//     - mem_state_e : FSM state encodings (MEM_IDLE / MEM_REQ / MEM_RESP)
//     - LANES_WORD / LANES_NONE : byte-lane enable constants
//     - lane_mask() : expands 4 byte-lane enables into a 32-bit data mask
// ----------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    localparam logic [3:0] LANES_WORD = 4'b1111;
    localparam logic [3:0] LANES_NONE = 4'b0000;

    // Each lane-enable bit becomes a full byte of ones in the mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
        return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/mem_access_watchdog.sv
// ----------------------------------------------------------------------------
// mem_watchdog
//   Wait-cycle counter used to abort bus transactions that never complete.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     clear_i    : synchronous clear (has priority over en_i)
//     en_i       : count one waiting cycle
//     expired_o  : the current waiting cycle is the TIMEOUT-th one
// ----------------------------------------------------------------------------
module mem_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    // The counter holds the number of waiting cycles already spent, so the
    // TIMEOUT-th waiting cycle is the one that sees cnt_q == TIMEOUT-1.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of en_i so the parent FSM can qualify it without a
    // combinational loop through the enable.
    assign expired_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_access.sv
// ----------------------------------------------------------------------------
// mem_access
//   Pipeline stage after Execute. Forwards ALU results to write-back with one
//   cycle of latency and performs LW/SW on the data-memory bus.
//
//   Bus handshake: dmem_req is asserted (with dmem_we/addr/wdata stable) from
//   the first REQ cycle and held until the cycle dmem_gnt is seen; the request
//   is accepted in that cycle. For loads, dmem_rvalid is only honoured in the
//   RESP state, i.e. at least one cycle after the grant; dmem_rdata is sampled
//   in the rvalid cycle.
//
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     EX_*            : instruction from Execute (ALU result, rd, mem fields)
//     MEM_stall       : upstream hold request (combinational)
//     dmem_*          : data-memory bus (req/gnt/rvalid)
//     MEM_x_rd_vld/MEM_x_rd/MEM_rd_idx : registered write-back
//     MEM_err         : 1-cycle pulse on misaligned/conflicting op or timeout
//     dbg_state_o     : current FSM state
// ----------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_x_rd_vld,
    input  logic [31:0] EX_x_rd,
    input  logic [4:0]  EX_rd_idx,
    input  logic [31:0] EX_MEMaddr,
    input  logic [3:0]  EX_MEMrden,
    input  logic [3:0]  EX_MEMwren,
    input  logic [31:0] EX_MEMwrdata,
    output logic        MEM_stall,
    output logic        dmem_req,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        MEM_x_rd_vld,
    output logic [31:0] MEM_x_rd,
    output logic [4:0]  MEM_rd_idx,
    output logic        MEM_err,
    output logic [1:0]  dbg_state_o
);

    mem_state_e state_q, state_d;

    // Latched memory operation
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  rden_q, rden_d;
    logic [3:0]  wren_q, wren_d;
    logic [4:0]  idx_q, idx_d;

    // Registered write-back / error outputs
    logic        wb_vld_q, wb_vld_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_idx_q, wb_idx_d;
    logic        err_q, err_d;

    logic stall_c;
    logic is_mem, misaligned, conflict, op_err;
    logic wd_clear, wd_en, wd_expired;

    assign is_mem     = (EX_MEMrden != LANES_NONE) || (EX_MEMwren != LANES_NONE);
    assign misaligned = ((EX_MEMrden | EX_MEMwren) == LANES_WORD) && (EX_MEMaddr[1:0] != 2'b00);
    assign conflict   = (EX_MEMrden != LANES_NONE) && (EX_MEMwren != LANES_NONE);
    assign op_err     = misaligned || conflict;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rden_d    = rden_q;
        wren_d    = wren_q;
        idx_d     = idx_q;
        wb_vld_d  = 1'b0;
        wb_data_d = wb_data_q;
        wb_idx_d  = wb_idx_q;
        err_d     = 1'b0;
        stall_c   = 1'b0;
        wd_en     = 1'b0;

        unique case (state_q)
            MEM_IDLE: begin
                if (is_mem) begin
                    if (op_err) begin
                        // Rejected before any bus activity; pipeline keeps moving.
                        err_d = 1'b1;
                    end else begin
                        addr_d  = {EX_MEMaddr[31:2], 2'b00};
                        wdata_d = EX_MEMwrdata;
                        rden_d  = EX_MEMrden;
                        wren_d  = EX_MEMwren;
                        idx_d   = EX_rd_idx;
                        state_d = MEM_REQ;
                        stall_c = 1'b1;
                    end
                end else begin
                    wb_vld_d  = EX_x_rd_vld;
                    wb_data_d = EX_x_rd;
                    wb_idx_d  = EX_rd_idx;
                end
            end

            MEM_REQ: begin
                // A coincident rvalid is deliberately ignored here.
                if (dmem_gnt) begin
                    if (rden_q != LANES_NONE) begin
                        state_d = MEM_RESP;
                        stall_c = 1'b1;
                    end else begin
                        state_d = MEM_IDLE;
                    end
                end else begin
                    wd_en = 1'b1;
                    if (wd_expired) begin
                        err_d   = 1'b1;
                        state_d = MEM_IDLE;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end

            MEM_RESP: begin
                if (dmem_rvalid) begin
                    wb_vld_d  = 1'b1;
                    wb_data_d = dmem_rdata & lane_mask(rden_q);
                    wb_idx_d  = idx_q;
                    state_d   = MEM_IDLE;
                end else begin
                    wd_en = 1'b1;
                    if (wd_expired) begin
                        err_d   = 1'b1;
                        state_d = MEM_IDLE;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end

            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    // Clearing on every state change restarts the count on entry to REQ and
    // to RESP; holding it clear in IDLE keeps it at zero between operations.
    assign wd_clear = (state_q == MEM_IDLE) || (state_d != state_q);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MEM_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rden_q    <= LANES_NONE;
            wren_q    <= LANES_NONE;
            idx_q     <= '0;
            wb_vld_q  <= 1'b0;
            wb_data_q <= '0;
            wb_idx_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
            idx_q     <= idx_d;
            wb_vld_q  <= wb_vld_d;
            wb_data_q <= wb_data_d;
            wb_idx_q  <= wb_idx_d;
            err_q     <= err_d;
        end
    end

    // Stall is combinational from EX inputs; masking with rst keeps it low
    // while reset is held even if Execute presents a memory op.
    assign MEM_stall = stall_c & ~rst;

    // Bus outputs are pure functions of the registered state, so dmem_req
    // falls together with the asynchronous reset of state_q.
    assign dmem_req   = (state_q == MEM_REQ);
    assign dmem_we    = dmem_req ? wren_q  : LANES_NONE;
    assign dmem_addr  = dmem_req ? addr_q  : 32'h0;
    assign dmem_wdata = dmem_req ? wdata_q : 32'h0;

    assign MEM_x_rd_vld = wb_vld_q;
    assign MEM_x_rd     = wb_data_q;
    assign MEM_rd_idx   = wb_idx_q;
    assign MEM_err      = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_access.sv
// ----------------------------------------------------------------------------
// tb_mem_access
//   Directed and randomized stimulus for mem_access (TIMEOUT=8). Each memory
//   operation is described by its fields plus the bus's grant delay and
//   rvalid delay; the expected stall length, request window, write-back and
//   error pulse are derived from those numbers.
// ----------------------------------------------------------------------------
module tb_mem_access;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EX_x_rd_vld = 1'b0;
    logic [31:0] EX_x_rd = '0;
    logic [4:0]  EX_rd_idx = '0;
    logic [31:0] EX_MEMaddr = '0;
    logic [3:0]  EX_MEMrden = '0;
    logic [3:0]  EX_MEMwren = '0;
    logic [31:0] EX_MEMwrdata = '0;
    logic        MEM_stall;
    logic        dmem_req;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        MEM_x_rd_vld;
    logic [31:0] MEM_x_rd;
    logic [4:0]  MEM_rd_idx;
    logic        MEM_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    mem_access #(
        .TIMEOUT (TMO),
        .CNT_W   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .EX_x_rd_vld  (EX_x_rd_vld),
        .EX_x_rd      (EX_x_rd),
        .EX_rd_idx    (EX_rd_idx),
        .EX_MEMaddr   (EX_MEMaddr),
        .EX_MEMrden   (EX_MEMrden),
        .EX_MEMwren   (EX_MEMwren),
        .EX_MEMwrdata (EX_MEMwrdata),
        .MEM_stall    (MEM_stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .MEM_x_rd_vld (MEM_x_rd_vld),
        .MEM_x_rd     (MEM_x_rd),
        .MEM_rd_idx   (MEM_rd_idx),
        .MEM_err      (MEM_err),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        EX_x_rd_vld  = 1'b0;
        EX_x_rd      = '0;
        EX_rd_idx    = '0;
        EX_MEMaddr   = '0;
        EX_MEMrden   = '0;
        EX_MEMwren   = '0;
        EX_MEMwrdata = '0;
    endtask

    // ---------------- drivers ----------------
    task automatic alu_op(input logic vld, input logic [31:0] v, input logic [4:0] rd);
        @(negedge clk);
        drive_nop();
        EX_x_rd_vld = vld;
        EX_x_rd     = v;
        EX_rd_idx   = rd;
        #1;
        check("alu_stall", MEM_stall, 0);
        check("alu_req", dmem_req, 0);
        @(negedge clk);
        check("alu_vld", MEM_x_rd_vld, vld);
        check("alu_data", MEM_x_rd, v);
        check("alu_idx", MEM_rd_idx, rd);
        check("alu_err", MEM_err, 0);
        drive_nop();
    endtask

    // g : waiting cycles in REQ before gnt (gnt in cycle 1+g, cycle 0 = accept)
    // r : waiting cycles in RESP before rvalid (rvalid in cycle 2+g+r)
    // rv_dup : also raise rvalid together with gnt
    task automatic mem_op(input logic [31:0] addr, input logic [3:0] rden, input logic [3:0] wren,
                          input logic [31:0] wd, input logic [4:0] rd, input int g, input int r,
                          input logic [31:0] rdata, input bit rv_dup);
        bit load_e, err_e, tmo_e, wb_e;
        int done, req_end;
        logic [31:0] exp_rd;

        // reference model
        load_e = (rden != 4'h0);
        err_e  = (((rden | wren) == 4'hF) && (addr[1:0] != 2'b00)) ||
                 ((rden != 4'h0) && (wren != 4'h0));
        tmo_e  = 1'b0;
        wb_e   = 1'b0;
        for (int b = 0; b < 4; b++) begin
            exp_rd[8*b +: 8] = rden[b] ? rdata[8*b +: 8] : 8'h00;
        end
        if (err_e) begin
            done = 0;
            req_end = 0;
        end else if (g >= TMO) begin
            done = TMO;
            req_end = TMO;
            tmo_e = 1'b1;
        end else if (!load_e) begin
            done = 1 + g;
            req_end = 1 + g;
        end else begin
            req_end = 1 + g;
            if (r >= TMO) begin
                done = 1 + g + TMO;
                tmo_e = 1'b1;
            end else begin
                done = 2 + g + r;
                wb_e = 1'b1;
            end
        end

        for (int c = 0; c <= done + 2; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                check("wb_vld", MEM_x_rd_vld, (c == done + 1) && wb_e);
                check("err", MEM_err, (c == done + 1) && (err_e || tmo_e));
                if (c == done + 1 && wb_e) begin
                    check("wb_data", MEM_x_rd, exp_rd);
                    check("wb_idx", MEM_rd_idx, rd);
                end
            end
            if (c <= done) begin
                EX_x_rd_vld  = 1'b0;
                EX_x_rd      = $urandom;
                EX_rd_idx    = rd;
                EX_MEMaddr   = addr;
                EX_MEMrden   = rden;
                EX_MEMwren   = wren;
                EX_MEMwrdata = wd;
            end else begin
                drive_nop();
            end
            dmem_gnt    = (c == 1 + g);
            dmem_rvalid = load_e && ((c == 2 + g + r) || (rv_dup && (c == 1 + g)));
            dmem_rdata  = dmem_rvalid ? rdata : ~rdata;
            #1;
            check("stall", MEM_stall, c < done);
            check("req", dmem_req, (c >= 1) && (c <= req_end));
            if (c >= 1 && c <= req_end) begin
                check("we", dmem_we, wren);
                check("addr", dmem_addr, {addr[31:2], 2'b00});
                if (!load_e) check("wdata", dmem_wdata, wd);
            end
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] lane_tab [7];
        logic [3:0] ln;
        logic [31:0] a;
        int kind, g, r;

        lane_tab = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};

        // reset state
        drive_nop();
        repeat (3) @(negedge clk);
        check("rst_stall", MEM_stall, 0);
        check("rst_req", dmem_req, 0);
        check("rst_vld", MEM_x_rd_vld, 0);
        check("rst_err", MEM_err, 0);
        check("rst_data", MEM_x_rd, 0);
        check("rst_idx", MEM_rd_idx, 0);
        rst = 1'b0;

        // directed
        alu_op(1'b1, 32'h5, 5'd3);
        mem_op(32'h100, 4'hF, 4'h0, 32'h0, 5'd7, 2, 0, 32'hDEADBEEF, 1'b0);
        mem_op(32'h104, 4'h0, 4'hF, 32'h12345678, 5'd0, 0, 0, 32'h0, 1'b0);
        mem_op(32'h102, 4'hF, 4'h0, 32'h0, 5'd4, 0, 0, 32'h11111111, 1'b0);   // misaligned
        mem_op(32'h200, 4'hF, 4'h0, 32'h0, 5'd5, 100, 0, 32'h0, 1'b0);        // gnt never
        mem_op(32'h300, 4'h1, 4'h2, 32'hCAFE, 5'd6, 0, 0, 32'h0, 1'b0);       // conflict
        mem_op(32'h301, 4'h2, 4'h0, 32'h0, 5'd8, 1, 2, 32'hAABBCCDD, 1'b0);   // byte load
        mem_op(32'h400, 4'hF, 4'h0, 32'h0, 5'd9, 0, 100, 32'h0, 1'b0);        // rvalid never
        mem_op(32'h404, 4'h0, 4'hF, 32'h55AA55AA, 5'd0, TMO, 0, 32'h0, 1'b0); // late gnt
        mem_op(32'h408, 4'hC, 4'h0, 32'h0, 5'd10, 1, 1, 32'h87654321, 1'b1);  // rvalid with gnt
        mem_op(32'h40C, 4'hF, 4'h0, 32'h0, 5'd0, 0, 0, 32'h0BADF00D, 1'b0);   // x0
        alu_op(1'b0, 32'h77, 5'd12);

        // randomized
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 9);
            ln   = lane_tab[$urandom_range(0, 6)];
            a    = $urandom;
            if (ln == 4'hF && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            g = ($urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(0, 3);
            r = ($urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(0, 3);
            if (kind == 0) begin
                mem_op(a, ln, lane_tab[$urandom_range(0, 6)], $urandom, 5'($urandom), g, r, $urandom, 1'b0);
            end else if (kind <= 5) begin
                mem_op(a, ln, 4'h0, $urandom, 5'($urandom), g, r, $urandom, $urandom_range(0, 1) == 1);
            end else if (kind <= 7) begin
                mem_op(a, 4'h0, ln, $urandom, 5'($urandom), g, r, $urandom, 1'b0);
            end else begin
                alu_op(1'b1, $urandom, 5'($urandom));
            end
        end

        // reset while in RESP
        @(negedge clk);
        drive_nop();
        EX_MEMaddr = 32'h500;
        EX_MEMrden = 4'hF;
        EX_rd_idx  = 5'd9;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check("resp_stall", MEM_stall, 1);
        rst = 1'b1;
        #1;
        check("arst_stall", MEM_stall, 0);
        check("arst_req", dmem_req, 0);
        check("arst_we", dmem_we, 0);
        check("arst_addr", dmem_addr, 0);
        check("arst_vld", MEM_x_rd_vld, 0);
        check("arst_data", MEM_x_rd, 0);
        check("arst_idx", MEM_rd_idx, 0);
        check("arst_err", MEM_err, 0);
        @(negedge clk);
        drive_nop();
        rst = 1'b0;
        alu_op(1'b1, 32'h1234, 5'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
